// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- owner encodings for the data-memory arbiter.
// These encodings are also the values of the arbiter's debug "owner" port,
// so the processor debug build shares this package to decode it.
package dmem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_IDLE = 2'b00;
    localparam owner_t OWN_CPU  = 2'b01;
    localparam owner_t OWN_DMA  = 2'b10;

endpackage

// File: rtl/dmem_arb_hold_cnt.sv
// dmem_arb_hold_cnt -- saturating counter of DMA accesses issued while the
// CPU is kept waiting.
// Ports:
//   clk     in   clock, posedge
//   rst     in   synchronous reset, active low
//   clr     in   clear (owner change); wins over inc
//   inc     in   count one DMA access
//   cnt     out  current count, 0..MAX_HOLD
//   at_max  out  cnt has reached MAX_HOLD
module dmem_arb_hold_cnt #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    assign at_max = (cnt == CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single data-memory port between the CPU
// load/store path and a DMA/loader master. A registered owner decides who may
// issue in the current cycle; the next owner is chosen at cycle end. Memory
// reads have one cycle of latency, so each ack is the registered issue strobe
// and read data is wired straight from memory.
//
// Build option: DMEM_ARB_RR_EN
//   undefined: fixed priority, CPU wins every contest (DMA may starve).
//   defined:   round-robin between the two requesters.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   cpu_req/we/addr/wdata         CPU access request
//   cpu_rdata, cpu_ack, cpu_stall CPU response; stall = req while not owner
//   dma_req/lock/we/addr/wdata    DMA access request; lock holds a burst
//   dma_rdata, dma_ack            DMA response
//   mem_addr/we/wdata, mem_rdata  memory port (1-cycle read latency)
//   owner                         current owner (debug)
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);
    import dmem_arb_pkg::*;

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    owner_t        owner_q;
    owner_t        owner_d;
    owner_t        tie_owner;
    logic          cpu_issue;
    logic          dma_issue;
    logic          hold_ok;
    logic [CW-1:0] hold_cnt;
    logic          hold_at_max;

    // Issue strobes are gated by reset so nothing reaches memory, and no ack
    // is generated, while reset is held.
    assign cpu_issue = rst && (owner_q == OWN_CPU) && cpu_req;
    assign dma_issue = rst && (owner_q == OWN_DMA) && dma_req;

    assign cpu_stall = cpu_req && (!rst || (owner_q != OWN_CPU));
    assign owner     = owner_q;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_issue) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_issue) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Who issued most recently; an IDLE tie goes to the other requester.
    logic last_dma;

    always_ff @(posedge clk) begin
        if (!rst)
            last_dma <= 1'b0;
        else if (cpu_issue)
            last_dma <= 1'b0;
        else if (dma_issue)
            last_dma <= 1'b1;
    end

    assign tie_owner = last_dma ? OWN_CPU : OWN_DMA;
`else
    assign tie_owner = OWN_CPU;
`endif

    // The access being issued this cycle is counted as well: a locked DMA may
    // keep the port only while this access is not yet its MAX_HOLD-th one.
    assign hold_ok = !hold_at_max && (hold_cnt != HOLD_LAST);

    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            OWN_IDLE: begin
                if (cpu_req && dma_req) owner_d = tie_owner;
                else if (cpu_req)       owner_d = OWN_CPU;
                else if (dma_req)       owner_d = OWN_DMA;
            end
            OWN_CPU: begin
                if (!cpu_req)
                    owner_d = dma_req ? OWN_DMA : OWN_IDLE;
`ifdef DMEM_ARB_RR_EN
                else if (dma_req)
                    owner_d = OWN_DMA;
`endif
            end
            OWN_DMA: begin
                if (!dma_req)
                    owner_d = cpu_req ? OWN_CPU : OWN_IDLE;
                else if (cpu_req && !(dma_lock && hold_ok))
                    owner_d = OWN_CPU;
            end
            default: owner_d = OWN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= OWN_IDLE;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            owner_q <= owner_d;
            cpu_ack <= cpu_issue;
            dma_ack <= dma_issue;
        end
    end

    dmem_arb_hold_cnt #(
        .MAX_HOLD(MAX_HOLD),
        .CW      (CW)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (owner_d != owner_q),
        .inc   (dma_issue && cpu_req),
        .cnt   (hold_cnt),
        .at_max(hold_at_max)
    );

endmodule
